load_store_unit: RTL
====================

# load_store_unit

Executes the memory-side half of loads and stores whose type the instruction decoder emits as an `LS_TYPE_*` code (memory.vh). The unit sits between the execute stage and data memory. It latches one request, checks alignment, and builds word-aligned byte-enabled memory transactions with a valid/ready handshake. It returns sign- or zero-extended load data and holds the pipeline stalled while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ+WAIT before aborting with `o_Error`; 8-bit counter.
- `i_Clock` in 1: single clock; all logic on rising edge.
- `i_Reset` in 1: synchronous, active-low reset.
- `i_Valid` in 1: execute stage presents a request this cycle.
- `i_Load_Store_Type` in LS_SEL_WIDTH+1: `LS_TYPE_*` code from the decoder.
- `i_Address` in 32: byte address (ALU result).
- `i_Store_Data` in 32: rs2 value.
- `o_Ready` in/out: out 1: unit is IDLE and will accept `i_Valid`.
- `o_Busy` out 1: stall request to pipeline; 1 in every state except IDLE.
- `o_Done` out 1: one-cycle completion pulse.
- `o_Error` out 1: valid with `o_Done`; misaligned access or timeout.
- `o_Load_Data` out 32: formatted load result, valid with `o_Done` for loads; held until next `o_Done`.
- `o_Mem_Valid` out 1: memory request valid.
- `o_Mem_Write` out 1: 1 = store, 0 = load.
- `o_Mem_Addr` out 32: `{addr[31:2], 2'b00}`.
- `o_Mem_Byte_Enable` out 4: lane enables.
- `o_Mem_Write_Data` out 32: lane-replicated store data.
- `i_Mem_Ready` in 1: memory accepts request.
- `i_Mem_Read_Valid` in 1: read data valid.
- `i_Mem_Read_Data` in 32: read word.

## Operation
- States are IDLE, REQ, WAIT, and DONE.
- **IDLE:** `o_Ready`=1. On `i_Valid` with type ≠ `LS_TYPE_NONE`, latch type, address and store data. A `LS_TYPE_NONE` request is ignored and the unit stays in IDLE.
  - If the latched access is misaligned, go to DONE with the error flag set.
  - Otherwise go to REQ.
- Misaligned means a half access (load/store half, load half unsigned) with `addr[0]`=1, or a word access with `addr[1:0]`≠0. Byte accesses are never misaligned.
- **REQ:** `o_Mem_Valid`=1. Address, write, byte-enable and data are stable until the handshake.
  - On `i_Mem_Ready`, a store goes to DONE and a load goes to WAIT.
- **WAIT:** on `i_Mem_Read_Valid`, capture the formatted data into `o_Load_Data` and go to DONE. `i_Mem_Read_Valid` is ignored outside WAIT.
- **DONE:** `o_Done`=1 for exactly one cycle, then return to IDLE.
- **Timeout:** the counter clears on entering REQ and increments each cycle in REQ or WAIT. Reaching `TIMEOUT_CYCLES` forces DONE with `o_Error`=1, drops `o_Mem_Valid`, and leaves `o_Load_Data` unchanged.
- **Byte enables:**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
  - Loads use the same enables.
- **Write data:**
  - Byte: `{4{data[7:0]}}`.
  - Half: `{2{data[15:0]}}`.
  - Word: unchanged.
- **Load format:** shift the word right by `8*addr[1:0]`, take the low byte or half, then sign-extend (load byte, load half) or zero-extend (load byte unsigned, load half unsigned). A word load is passed through.
- Store type codes never write `o_Load_Data`.

## Timing
- **Reset** (`i_Reset`=0 at an edge): state IDLE, timeout counter 0. The following outputs all read 0:
  - `o_Busy`, `o_Done`, `o_Error`, `o_Load_Data`
  - `o_Mem_Valid`, `o_Mem_Write`, `o_Mem_Addr`, `o_Mem_Byte_Enable`, `o_Mem_Write_Data`
- `o_Ready` is 1 after reset.
- **Reset mid-transaction:** the transaction is abandoned with no `o_Done`, and `o_Mem_Valid` is 0 the cycle after the reset edge.
- All outputs are registered or decoded from state only; there is no combinational path from `i_Mem_*` to `o_Mem_*`.
- **Latency** (accept edge = cycle 0):
  - Store with immediate ready: REQ cycle 1, `o_Done` cycle 2.
  - Load with ready at cycle 1 and read-valid at cycle 2: `o_Done` cycle 3.
  - Misaligned access: `o_Done`+`o_Error` at cycle 1, and `o_Mem_Valid` is never asserted.
- Each cycle `i_Mem_Ready` is low in REQ adds one cycle; likewise each cycle `i_Mem_Read_Valid` is low in WAIT.
- `i_Valid` while not IDLE is ignored; the pipeline must be stalled by `o_Busy`.
- **Timeout wins** if it coincides with `i_Mem_Ready` or `i_Mem_Read_Valid` in the same cycle: the result is an error and no data is captured.
- Back-to-back requests: the next request may be accepted in the cycle after DONE.

## Test plan
- **Load byte, sign-extended:** LB at addr 0x103, memory word 0x80FF_1234, ready at cycle 1, read-valid at cycle 2 → byte-enable 4'b1000, mem addr 0x100; `o_Done` at cycle 3 with `o_Load_Data`=0xFFFF_FF80, `o_Error`=0.
- **Store half, upper lane:** SH at addr 0x22, data 0xDEAD_BEEF → mem addr 0x20, byte-enable 4'b1100, write data 0xBEEF_BEEF, `o_Mem_Write`=1; `o_Done` at cycle 2.
- **Unsigned loads:** LHU at 0x02 of 0x8001_7FFF → 0x0000_8001; LBU at 0x00 → 0x0000_00FF.
- **Misaligned:** LW at 0x06 → no `o_Mem_Valid`; `o_Done`=1 and `o_Error`=1 at cycle 1; `o_Load_Data` unchanged.
- **Stall and timeout:** hold `i_Mem_Ready` low for 3 cycles → `o_Mem_*` stable and `o_Busy`=1 throughout, `o_Done` at cycle 5. Then never assert read-valid with `TIMEOUT_CYCLES`=4 → `o_Error` with `o_Done` 4 cycles after entering REQ.
- **Reset during WAIT:** `o_Busy`=0, no `o_Done`, `o_Ready`=1 the cycle after reset; a subsequent LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: latches one load/store, checks alignment, drives a byte-enabled memory handshake with timeout and formats load data.
module load_store_unit #(
    parameter int LS_SEL_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
    input  logic [31:0]           i_Address,
    input  logic [31:0]           i_Store_Data,
    output logic                  o_Ready,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic [31:0]           o_Load_Data,
    output logic                  o_Mem_Valid,
    output logic                  o_Mem_Write,
    output logic [31:0]           o_Mem_Addr,
    output logic [3:0]            o_Mem_Byte_Enable,
    output logic [31:0]           o_Mem_Write_Data,
    input  logic                  i_Mem_Ready,
    input  logic                  i_Mem_Read_Valid,
    input  logic [31:0]           i_Mem_Read_Data
);
    localparam int TW = LS_SEL_WIDTH + 1;
    localparam logic [TW-1:0] LS_TYPE_NONE = TW'(0);
    localparam logic [TW-1:0] LS_TYPE_LB   = TW'(1);
    localparam logic [TW-1:0] LS_TYPE_LH   = TW'(2);
    localparam logic [TW-1:0] LS_TYPE_LW   = TW'(3);
    localparam logic [TW-1:0] LS_TYPE_LBU  = TW'(4);
    localparam logic [TW-1:0] LS_TYPE_LHU  = TW'(5);
    localparam logic [TW-1:0] LS_TYPE_SB   = TW'(6);
    localparam logic [TW-1:0] LS_TYPE_SH   = TW'(7);
    localparam logic [TW-1:0] LS_TYPE_SW   = TW'(8);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // Access size: 0 = no access, 1 = byte, 2 = half, 3 = word
    function automatic logic [1:0] size_of(input logic [TW-1:0] t);
        return (t == LS_TYPE_LB || t == LS_TYPE_LBU || t == LS_TYPE_SB) ? 2'd1 :
               (t == LS_TYPE_LH || t == LS_TYPE_LHU || t == LS_TYPE_SH) ? 2'd2 :
               (t == LS_TYPE_LW || t == LS_TYPE_SW) ? 2'd3 : 2'd0;
    endfunction

    state_t        state, state_next;
    logic [TW-1:0] ls_type;
    logic [31:0]   addr, wdata, load_data, shifted, fmt;
    logic [7:0]    cnt;
    logic [1:0]    in_size, size;
    logic          err, accept, in_misaligned, timeout, is_store;

    assign in_size       = size_of(i_Load_Store_Type);
    assign size          = size_of(ls_type);
    assign accept        = state == S_IDLE && i_Valid && in_size != 2'd0;
    assign in_misaligned = (in_size == 2'd2 && i_Address[0]) || (in_size == 2'd3 && |i_Address[1:0]);
    assign timeout       = (state == S_REQ || state == S_WAIT) && cnt == 8'(TIMEOUT_CYCLES - 1);
    assign is_store      = ls_type == LS_TYPE_SB || ls_type == LS_TYPE_SH || ls_type == LS_TYPE_SW;
    assign shifted       = i_Mem_Read_Data >> {addr[1:0], 3'b000};
    assign fmt = ls_type == LS_TYPE_LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                 ls_type == LS_TYPE_LBU ? {24'b0, shifted[7:0]} :
                 ls_type == LS_TYPE_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                 ls_type == LS_TYPE_LHU ? {16'b0, shifted[15:0]} : i_Mem_Read_Data;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state     <= S_IDLE;
            ls_type   <= LS_TYPE_NONE;
            addr      <= '0;
            wdata     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ls_type <= i_Load_Store_Type;
                addr    <= i_Address;
                wdata   <= i_Store_Data;
                err     <= in_misaligned;
            end
            if (timeout)
                err <= 1'b1;
            // Held at zero outside REQ/WAIT so it starts clean on entering REQ
            cnt <= (state == S_REQ || state == S_WAIT) ? cnt + 8'd1 : 8'd0;
            if (state == S_WAIT && i_Mem_Read_Valid && !timeout)
                load_data <= fmt;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = in_misaligned ? S_DONE : S_REQ;
            S_REQ:   if (timeout) state_next = S_DONE;
                     else if (i_Mem_Ready) state_next = is_store ? S_DONE : S_WAIT;
            S_WAIT:  if (timeout || i_Mem_Read_Valid) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Ready           = state == S_IDLE;
        o_Busy            = state != S_IDLE;
        o_Done            = state == S_DONE;
        o_Error           = state == S_DONE && err;
        o_Load_Data       = load_data;
        o_Mem_Valid       = state == S_REQ;
        o_Mem_Write       = is_store;
        o_Mem_Addr        = {addr[31:2], 2'b00};
        o_Mem_Byte_Enable = size == 2'd1 ? 4'b0001 << addr[1:0] :
                            size == 2'd2 ? 4'b0011 << addr[1:0] :
                            size == 2'd3 ? 4'b1111 : 4'b0000;
        o_Mem_Write_Data  = size == 2'd1 ? {4{wdata[7:0]}} :
                            size == 2'd2 ? {2{wdata[15:0]}} : wdata;
    end
endmodule
